hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the clock port named clk and the reset port named rst.
REQ-002 Parameter FLUSH_CYCLES, default 2, SHALL set the number of cycles IF/ID is flushed after a taken branch (legal 1..7).
REQ-003 Parameter MEM_TIMEOUT, default 15, SHALL set the maximum MEM_WAIT cycles before timeout (legal 1..255).
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  async active-high reset
- ID_EX_MemRead  in  1  EX-stage instruction is a load
- ID_EX_Rt  in  5  load destination
- IF_ID_Rs  in  5  ID-stage source A
- IF_ID_Rt  in  5  ID-stage source B
- IF_ID_usesRt  in  1  ID-stage instruction reads Rt
- branch_taken  in  1  branch resolved taken in EX
- dmem_req  in  1  MEM-stage memory access
- dmem_ready  in  1  memory completes this cycle
- stall_IF  out  1  hold PC
- stall_ID  out  1  hold IF/ID
- bubble_EX  out  1  insert NOP into ID/EX
- flush_IF_ID  out  1  clear IF/ID
- stall_mem  out  1  freeze all pipeline registers
- mem_timeout  out  1  sticky error
- stall_cnt  out  16  stall-cycle count (HAZARD_PERF_CNT_EN only)

Function
REQ-005 load_use SHALL be ID_EX_MemRead & ((ID_EX_Rt==IF_ID_Rs & IF_ID_Rs!=5'h9) | (IF_ID_usesRt & ID_EX_Rt==IF_ID_Rt & IF_ID_Rt!=5'h9)); r9 is always forwarded and SHALL never stall.
REQ-006 The FSM SHALL have exactly four states: RUN, MEM_WAIT, FLUSH and TIMEOUT_RECOVER.
- All outputs are combinational from state plus the current-cycle inputs.
- Event priority: memory wait > branch > load-use.
REQ-007 In RUN:
- If dmem_req & ~dmem_ready: stall_mem=1 this cycle; next state MEM_WAIT; wait counter loads 1.
- Else if branch_taken: flush_IF_ID=1 and bubble_EX=1 this cycle. If FLUSH_CYCLES>1, flush counter loads FLUSH_CYCLES-1 and next state is FLUSH; otherwise remain in RUN.
- Else if load_use: stall_IF=stall_ID=bubble_EX=1 for exactly this cycle; remain in RUN.
REQ-008 In MEM_WAIT:
- stall_mem SHALL equal ~dmem_ready.
- On dmem_ready, next state is RUN with zero added latency; branch_taken and load_use SHALL be ignored in this state.
- Otherwise the wait counter increments.
- If the counter equals MEM_TIMEOUT and dmem_ready=0: set mem_timeout; next state TIMEOUT_RECOVER.
REQ-009 TIMEOUT_RECOVER SHALL assert flush_IF_ID=1 and bubble_EX=1 for exactly one cycle, then go to RUN.
REQ-010 In FLUSH:
- flush_IF_ID=1 every cycle; the flush counter decrements and the state goes to RUN in the cycle after the counter reaches 0.
- If dmem_req & ~dmem_ready occurs in FLUSH, stall_mem=1 and the flush counter holds (no decrement) that cycle.
REQ-011 Simultaneous branch_taken and load_use in RUN SHALL produce the branch response only (stall_IF=stall_ID=0).
REQ-012 mem_timeout SHALL be sticky and cleared only by rst.

Reset
REQ-013 Asserting rst SHALL immediately force the state to RUN, clear all counters, clear mem_timeout and stall_cnt, and drive every output to 0.
REQ-014 rst asserted mid-MEM_WAIT or mid-FLUSH SHALL abandon the operation; the first cycle after release behaves as RUN.

Configuration
REQ-015 The macro HAZARD_PERF_CNT_EN SHALL control the stall_cnt feature:
- When defined, the stall_cnt port exists and increments by 1 each cycle in which any of stall_IF, stall_mem or flush_IF_ID is 1, saturating at 16'hFFFF.
- When undefined, the port and its counter are absent and all other behaviour is unchanged.

Structure
REQ-016 Package hazard_pkg SHALL hold:
- the state enum hz_state_t;
- the constant REG_FWD_SPECIAL = 5'h9;
- the constant REG_W = 5;
- the width constants for the flush counter (3) and wait counter (8).
REQ-017 The load-use comparison SHALL be a combinational sub-module hazard_load_use_det; the FSM and counters reside in hazard_ctrl.

Verification
REQ-018 Directed scenarios:
- Load-use: ID_EX_MemRead=1, ID_EX_Rt=3, IF_ID_Rs=3 -> stall_IF=stall_ID=bubble_EX=1 for one cycle. Repeated with Rs=9 -> no stall.
- Branch: branch_taken=1 with FLUSH_CYCLES=2 -> flush_IF_ID=1 for 2 consecutive cycles, bubble_EX=1 in the first cycle only, then RUN.
- Memory wait: dmem_req=1, dmem_ready=0 for 4 cycles, then 1 -> stall_mem=1 for 4 cycles and 0 in the ready cycle; mem_timeout=0.
- Timeout: MEM_TIMEOUT=15, dmem_ready held 0 -> mem_timeout rises on cycle 15 and stays 1; TIMEOUT_RECOVER flush occurs; mem_timeout cleared only by rst.
- Priority and reset: simultaneous branch_taken, load_use and dmem_req&~dmem_ready -> only stall_mem=1. rst pulsed during FLUSH -> all outputs 0 immediately, RUN after release.
- With HAZARD_PERF_CNT_EN: the scenarios above -> stall_cnt equals the total count of qualifying cycles.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Used by hazard_ctrl and hazard_load_use_det.
package hazard_pkg;

  localparam int REG_W       = 5;
  localparam int FLUSH_CNT_W = 3;
  localparam int WAIT_CNT_W  = 8;

  // r9 is always satisfied by the forwarding network, so it never causes a load-use stall
  localparam logic [REG_W-1:0] REG_FWD_SPECIAL = 5'h9;

  typedef enum logic [1:0] {
    RUN             = 2'd0,
    MEM_WAIT        = 2'd1,
    FLUSH           = 2'd2,
    TIMEOUT_RECOVER = 2'd3
  } hz_state_t;

endpackage

// File: rtl/hazard_load_use_det.sv
// Combinational load-use detector comparing the EX-stage load destination
// against the ID-stage source registers.
module hazard_load_use_det
  import hazard_pkg::*;
(
  input  logic             memRead_i,
  input  logic [REG_W-1:0] exRt_i,
  input  logic [REG_W-1:0] idRs_i,
  input  logic [REG_W-1:0] idRt_i,
  input  logic             idUsesRt_i,
  output logic             loadUse_o
);

  logic rsHit;
  logic rtHit;

  assign rsHit     = (exRt_i == idRs_i) && (idRs_i != REG_FWD_SPECIAL);
  assign rtHit     = idUsesRt_i && (exRt_i == idRt_i) && (idRt_i != REG_FWD_SPECIAL);
  assign loadUse_o = memRead_i && (rsHit || rtHit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait freezes and timeout recovery.
// Define HAZARD_PERF_CNT_EN to add the saturating stall_cnt performance counter port.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_Rt,
  input  logic [REG_W-1:0] IF_ID_Rs,
  input  logic [REG_W-1:0] IF_ID_Rt,
  input  logic             IF_ID_usesRt,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             bubble_EX,
  output logic             flush_IF_ID,
  output logic             stall_mem,
  output logic             mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0]  WAIT_LIMIT = WAIT_CNT_W'(MEM_TIMEOUT);

  hz_state_t              state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flushCnt_q, flushCnt_d;
  logic [WAIT_CNT_W-1:0]  waitCnt_q, waitCnt_d;
  logic                   memTimeout_q, memTimeout_d;

  logic loadUse;
  logic memMiss;
  logic stallIf, stallId, bubbleEx, flushIfId, stallMem;

  hazard_load_use_det uLoadUse (
    .memRead_i  (ID_EX_MemRead),
    .exRt_i     (ID_EX_Rt),
    .idRs_i     (IF_ID_Rs),
    .idRt_i     (IF_ID_Rt),
    .idUsesRt_i (IF_ID_usesRt),
    .loadUse_o  (loadUse)
  );

  assign memMiss = dmem_req && !dmem_ready;

  // Priority inside RUN is memory wait, then branch, then load-use
  always_comb begin
    state_d      = state_q;
    flushCnt_d   = flushCnt_q;
    waitCnt_d    = waitCnt_q;
    memTimeout_d = memTimeout_q;
    stallIf      = 1'b0;
    stallId      = 1'b0;
    bubbleEx     = 1'b0;
    flushIfId    = 1'b0;
    stallMem     = 1'b0;
    case (state_q)
      RUN: begin
        if (memMiss) begin
          stallMem  = 1'b1;
          waitCnt_d = WAIT_CNT_W'(1);
          state_d   = MEM_WAIT;
        end else if (branch_taken) begin
          flushIfId = 1'b1;
          bubbleEx  = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flushCnt_d = FLUSH_LOAD;
            state_d    = FLUSH;
          end
        end else if (loadUse) begin
          stallIf  = 1'b1;
          stallId  = 1'b1;
          bubbleEx = 1'b1;
        end
      end
      MEM_WAIT: begin
        stallMem = !dmem_ready;
        if (dmem_ready) begin
          waitCnt_d = '0;
          state_d   = RUN;
        end else if (waitCnt_q == WAIT_LIMIT) begin
          memTimeout_d = 1'b1;
          waitCnt_d    = '0;
          state_d      = TIMEOUT_RECOVER;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      FLUSH: begin
        flushIfId = 1'b1;
        // A memory stall freezes the flush countdown along with the rest of the pipe
        if (memMiss) begin
          stallMem = 1'b1;
        end else if (flushCnt_q <= FLUSH_CNT_W'(1)) begin
          flushCnt_d = '0;
          state_d    = RUN;
        end else begin
          flushCnt_d = flushCnt_q - 1'b1;
        end
      end
      TIMEOUT_RECOVER: begin
        flushIfId = 1'b1;
        bubbleEx  = 1'b1;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign stall_IF    = stallIf   && !rst;
  assign stall_ID    = stallId   && !rst;
  assign bubble_EX   = bubbleEx  && !rst;
  assign flush_IF_ID = flushIfId && !rst;
  assign stall_mem   = stallMem  && !rst;
  assign mem_timeout = memTimeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      flushCnt_q   <= '0;
      waitCnt_q    <= '0;
      memTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flushCnt_q   <= flushCnt_d;
      waitCnt_q    <= waitCnt_d;
      memTimeout_q <= memTimeout_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stallCnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt_q <= '0;
    end else if ((stall_IF || stall_mem || flush_IF_ID) && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_q <= stallCnt_q + 16'd1;
    end
  end

  assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a table of single-cycle RUN vectors plus
// directed multi-cycle sequences, with expected outputs queued per driven cycle.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_Rt;
  logic [4:0] IF_ID_Rs;
  logic [4:0] IF_ID_Rt;
  logic       IF_ID_usesRt;
  logic       branch_taken;
  logic       dmem_req;
  logic       dmem_ready;
  logic       stall_IF, stall_ID, bubble_EX, flush_IF_ID, stall_mem, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt;
  int          expCnt = 0;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       rst;
    logic       memRead;
    logic [4:0] exRt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       br;
    logic       req;
    logic       rdy;
  } stim_t;

  // Expected outputs are {stall_IF, stall_ID, bubble_EX, flush_IF_ID, stall_mem}
  typedef struct packed {
    stim_t      s;
    logic [4:0] exp;
  } vec_t;

  logic [5:0] expQ[$];
  string      nameQ[$];

  hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .ID_EX_MemRead (ID_EX_MemRead),
    .ID_EX_Rt      (ID_EX_Rt),
    .IF_ID_Rs      (IF_ID_Rs),
    .IF_ID_Rt      (IF_ID_Rt),
    .IF_ID_usesRt  (IF_ID_usesRt),
    .branch_taken  (branch_taken),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .stall_IF      (stall_IF),
    .stall_ID      (stall_ID),
    .bubble_EX     (bubble_EX),
    .flush_IF_ID   (flush_IF_ID),
    .stall_mem     (stall_mem),
    .mem_timeout   (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic memRead, input logic [4:0] exRt, input logic [4:0] rs,
                               input logic [4:0] rt, input logic usesRt, input logic br,
                               input logic req, input logic rdy);
    stim_t s;
    s.rst     = 1'b0;
    s.memRead = memRead;
    s.exRt    = exRt;
    s.rs      = rs;
    s.rt      = rt;
    s.usesRt  = usesRt;
    s.br      = br;
    s.req     = req;
    s.rdy     = rdy;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst           = s.rst;
    ID_EX_MemRead = s.memRead;
    ID_EX_Rt      = s.exRt;
    IF_ID_Rs      = s.rs;
    IF_ID_Rt      = s.rt;
    IF_ID_usesRt  = s.usesRt;
    branch_taken  = s.br;
    dmem_req      = s.req;
    dmem_ready    = s.rdy;
  endtask

  task automatic checkOutput();
    logic [5:0] want;
    logic [5:0] got;
    string      nm;
    if (expQ.size() == 0) begin
      bad++;
      total++;
      $display("[TB] FAIL scoreboard: got=empty queue want=entry");
      return;
    end
    want = expQ.pop_front();
    nm   = nameQ.pop_front();
    got  = {stall_IF, stall_ID, bubble_EX, flush_IF_ID, stall_mem, mem_timeout};
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%b want=%b (IF ID EX flush mem timeout)", nm, got, want);
    end
`ifdef HAZARD_PERF_CNT_EN
    if (rst) expCnt = 0;
    total++;
    if (stall_cnt !== 16'(expCnt)) begin
      bad++;
      $display("[TB] FAIL %s.stall_cnt: got=%0d want=%0d", nm, stall_cnt, expCnt);
    end
    if (!rst && (want[5] || want[2] || want[1]) && expCnt < 16'hFFFF) expCnt++;
`endif
  endtask

  task automatic applyStimulus(input stim_t s, input logic [4:0] e, input logic mt, input string nm);
    @(posedge clk);
    #1;
    drive(s);
    expQ.push_back({e, mt});
    nameQ.push_back(nm);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    vec_t  tbl[9];
    stim_t idle;
    stim_t lu;
    stim_t br;
    stim_t miss;
    stim_t s;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    lu   = mk(1, 3, 3, 0, 0, 0, 0, 0);
    br   = mk(0, 0, 0, 0, 0, 1, 0, 0);
    miss = mk(0, 0, 0, 0, 0, 0, 1, 0);

    tbl[0] = '{mk(1, 3, 3, 0, 0, 0, 0, 0), 5'b11100};
    tbl[1] = '{mk(1, 9, 9, 0, 0, 0, 0, 0), 5'b00000};
    tbl[2] = '{mk(1, 5, 1, 5, 1, 0, 0, 0), 5'b11100};
    tbl[3] = '{mk(1, 5, 1, 5, 0, 0, 0, 0), 5'b00000};
    tbl[4] = '{mk(1, 9, 1, 9, 1, 0, 0, 0), 5'b00000};
    tbl[5] = '{mk(0, 3, 3, 3, 1, 0, 0, 0), 5'b00000};
    tbl[6] = '{mk(1, 3, 4, 6, 1, 0, 0, 0), 5'b00000};
    tbl[7] = '{mk(1, 0, 0, 0, 0, 0, 1, 1), 5'b11100};
    tbl[8] = '{mk(0, 0, 0, 0, 0, 0, 1, 1), 5'b00000};

    s = mk(1, 3, 3, 0, 0, 1, 1, 0);
    s.rst = 1'b1;
    drive(s);
    applyStimulus(s, 5'b00000, 1'b0, "reset");
    applyStimulus(idle, 5'b00000, 1'b0, "post_reset");

    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].s, tbl[i].exp, 1'b0, $sformatf("tbl%0d", i));
    end

    applyStimulus(br, 5'b00110, 1'b0, "br_c1");
    applyStimulus(idle, 5'b00010, 1'b0, "br_c2");
    applyStimulus(lu, 5'b11100, 1'b0, "br_run");

    applyStimulus(mk(1, 3, 3, 0, 0, 1, 0, 0), 5'b00110, 1'b0, "br_lu_c1");
    applyStimulus(lu, 5'b00010, 1'b0, "br_lu_c2");
    applyStimulus(idle, 5'b00000, 1'b0, "br_lu_run");

    applyStimulus(miss, 5'b00001, 1'b0, "mw_c1");
    applyStimulus(miss, 5'b00001, 1'b0, "mw_c2");
    applyStimulus(mk(1, 3, 3, 0, 0, 1, 1, 0), 5'b00001, 1'b0, "mw_c3_ignore");
    applyStimulus(miss, 5'b00001, 1'b0, "mw_c4");
    applyStimulus(mk(1, 3, 3, 0, 0, 1, 1, 1), 5'b00000, 1'b0, "mw_ready");
    applyStimulus(idle, 5'b00000, 1'b0, "mw_run");

    applyStimulus(mk(1, 3, 3, 0, 0, 1, 1, 0), 5'b00001, 1'b0, "prio_all");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 1), 5'b00000, 1'b0, "prio_ready");
    applyStimulus(idle, 5'b00000, 1'b0, "prio_run");

    applyStimulus(br, 5'b00110, 1'b0, "fl_hold_c1");
    applyStimulus(miss, 5'b00011, 1'b0, "fl_hold_miss");
    applyStimulus(idle, 5'b00010, 1'b0, "fl_hold_c2");
    applyStimulus(idle, 5'b00000, 1'b0, "fl_hold_run");

    applyStimulus(br, 5'b00110, 1'b0, "rstfl_br");
    s = mk(1, 3, 3, 0, 0, 1, 1, 0);
    s.rst = 1'b1;
    applyStimulus(s, 5'b00000, 1'b0, "rstfl_rst");
    applyStimulus(idle, 5'b00000, 1'b0, "rstfl_rel");
    applyStimulus(lu, 5'b11100, 1'b0, "rstfl_lu");

    applyStimulus(miss, 5'b00001, 1'b0, "rstmw_c1");
    applyStimulus(miss, 5'b00001, 1'b0, "rstmw_c2");
    s = miss;
    s.rst = 1'b1;
    applyStimulus(s, 5'b00000, 1'b0, "rstmw_rst");
    applyStimulus(idle, 5'b00000, 1'b0, "rstmw_rel");

    // Ready arriving on the last legal wait cycle must not time out
    applyStimulus(miss, 5'b00001, 1'b0, "near_c0");
    for (int k = 1; k <= 14; k++) begin
      applyStimulus(miss, 5'b00001, 1'b0, $sformatf("near_c%0d", k));
    end
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 1), 5'b00000, 1'b0, "near_ready");
    applyStimulus(idle, 5'b00000, 1'b0, "near_run");

    applyStimulus(miss, 5'b00001, 1'b0, "to_c0");
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(miss, 5'b00001, 1'b0, $sformatf("to_c%0d", k));
    end
    applyStimulus(idle, 5'b00110, 1'b1, "to_recover");
    applyStimulus(idle, 5'b00000, 1'b1, "to_run");
    applyStimulus(br, 5'b00110, 1'b1, "to_sticky_br");
    applyStimulus(idle, 5'b00010, 1'b1, "to_sticky_fl");
    applyStimulus(idle, 5'b00000, 1'b1, "to_sticky_run");
    s = idle;
    s.rst = 1'b1;
    applyStimulus(s, 5'b00000, 1'b0, "to_rst");
    applyStimulus(idle, 5'b00000, 1'b0, "to_after_rst");

    if (expQ.size() != 0) begin
      bad++;
      total++;
      $display("[TB] FAIL scoreboard_drain: got=%0d left want=0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
